// File: rtl/sprite_loc_ctrl_if.sv
// Probe and redraw handshake between the sprite location controller (master)
// and the map RAM lookup / RAM-write logic (slave).
interface sprite_loc_ctrl_if #(
    parameter int X_W = 6,
    parameter int Y_W = 5
) ();
    logic           probe_req;
    logic [X_W-1:0] probe_x;
    logic [Y_W-1:0] probe_y;
    logic           probe_ack;
    logic           probe_wall;
    logic           ready;
    logic           done;
    logic [X_W-1:0] next_x;
    logic [Y_W-1:0] next_y;

    modport master (
        output probe_req, probe_x, probe_y, ready, next_x, next_y,
        input  probe_ack, probe_wall, done
    );

    modport slave (
        input  probe_req, probe_x, probe_y, ready, next_x, next_y,
        output probe_ack, probe_wall, done
    );
endinterface

// File: rtl/sprite_loc_ctrl.sv
// Grid-location controller for one maze sprite: buffers the requested turn,
// probes target cells against the map and hands committed moves to the RAM writer.
//   state  | meaning
//   IDLE   | waiting for step; next == curr
//   P_WANT | probing curr + buffered turn direction
//   P_HEAD | probing curr + current heading
//   COMMIT | ready high, waiting for done from the RAM writer
module sprite_loc_ctrl #(
    parameter int X_W     = 6,
    parameter int Y_W     = 5,
    parameter int GRID_W  = 40,
    parameter int GRID_H  = 30,
    parameter int START_X = 20,
    parameter int START_Y = 20,
    parameter int WRAP    = 1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              up,
    input  logic              down,
    input  logic              left,
    input  logic              right,
    input  logic              step,
    sprite_loc_ctrl_if.master bus,
    output logic [X_W-1:0]    curr_x,
    output logic [Y_W-1:0]    curr_y,
    output logic [1:0]        heading,
    output logic              moving,
    output logic              blocked
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] P_WANT = 2'd1;
    localparam logic [1:0] P_HEAD = 2'd2;
    localparam logic [1:0] COMMIT = 2'd3;

    localparam logic [X_W-1:0] X_MAX   = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_MAX   = Y_W'(GRID_H - 1);
    localparam logic [X_W-1:0] X_START = X_W'(START_X);
    localparam logic [Y_W-1:0] Y_START = Y_W'(START_Y);
    localparam logic           NO_WRAP = (WRAP == 0);

    logic [1:0]     state_q, state_d;
    logic [X_W-1:0] curr_x_q, curr_x_d, next_x_q, next_x_d, probe_x_q, probe_x_d;
    logic [Y_W-1:0] curr_y_q, curr_y_d, next_y_q, next_y_d, probe_y_q, probe_y_d;
    logic [1:0]     heading_q, heading_d, want_dir_q, want_dir_d, probe_dir_q, probe_dir_d;
    logic           moving_q, moving_d, want_valid_q, want_valid_d;
    logic           probe_req_q, probe_req_d, off_q, off_d;
    logic           ready_q, ready_d, blocked_q, blocked_d;
    logic           any_dir;
    logic [X_W+Y_W:0] want_cell, head_cell;

    // Returns {off_grid, x, y} of the neighbour cell; wraps modulo the grid, not the bit width.
    function automatic logic [X_W+Y_W:0] adj_cell(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y,
                                                  input logic [1:0]     d);
        logic [X_W-1:0] nx;
        logic [Y_W-1:0] ny;
        logic           off;
        nx  = x;
        ny  = y;
        off = 1'b0;
        case (d)
            2'd0: if (y == '0) begin ny = Y_MAX; off = NO_WRAP; end else ny = y - Y_W'(1);
            2'd1: if (y == Y_MAX) begin ny = '0; off = NO_WRAP; end else ny = y + Y_W'(1);
            2'd2: if (x == '0) begin nx = X_MAX; off = NO_WRAP; end else nx = x - X_W'(1);
            default: if (x == X_MAX) begin nx = '0; off = NO_WRAP; end else nx = x + X_W'(1);
        endcase
        return {off, nx, ny};
    endfunction

    assign want_cell = adj_cell(curr_x_q, curr_y_q, want_dir_q);
    assign head_cell = adj_cell(curr_x_q, curr_y_q, heading_q);
    assign any_dir   = up | down | left | right;

    always_comb begin
        state_d      = state_q;
        curr_x_d     = curr_x_q;
        curr_y_d     = curr_y_q;
        next_x_d     = next_x_q;
        next_y_d     = next_y_q;
        probe_x_d    = probe_x_q;
        probe_y_d    = probe_y_q;
        heading_d    = heading_q;
        want_dir_d   = want_dir_q;
        probe_dir_d  = probe_dir_q;
        moving_d     = moving_q;
        want_valid_d = want_valid_q | any_dir;
        probe_req_d  = probe_req_q;
        off_d        = off_q;
        ready_d      = ready_q;
        blocked_d    = blocked_q;

        if (up)         want_dir_d = 2'd0;
        else if (down)  want_dir_d = 2'd1;
        else if (left)  want_dir_d = 2'd2;
        else if (right) want_dir_d = 2'd3;

        case (state_q)
            IDLE: begin
                if (step && want_valid_q) begin
                    state_d     = P_WANT;
                    probe_dir_d = want_dir_q;
                    {off_d, probe_x_d, probe_y_d} = want_cell;
                    probe_req_d = ~want_cell[X_W+Y_W];
                end else if (step && moving_q) begin
                    state_d = P_HEAD;
                    {off_d, probe_x_d, probe_y_d} = head_cell;
                    probe_req_d = ~head_cell[X_W+Y_W];
                end
            end
            P_WANT: begin
                if (off_q || bus.probe_ack) begin
                    probe_req_d = 1'b0;
                    if (!off_q && !bus.probe_wall) begin
                        heading_d = probe_dir_q;
                        moving_d  = 1'b1;
                        if (!any_dir) want_valid_d = 1'b0;
                        next_x_d  = probe_x_q;
                        next_y_d  = probe_y_q;
                        blocked_d = 1'b0;
                        ready_d   = 1'b1;
                        state_d   = COMMIT;
                    end else if (moving_q) begin
                        state_d = P_HEAD;
                        {off_d, probe_x_d, probe_y_d} = head_cell;
                        probe_req_d = ~head_cell[X_W+Y_W];
                    end else begin
                        blocked_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            P_HEAD: begin
                if (off_q || bus.probe_ack) begin
                    probe_req_d = 1'b0;
                    if (!off_q && !bus.probe_wall) begin
                        next_x_d  = probe_x_q;
                        next_y_d  = probe_y_q;
                        blocked_d = 1'b0;
                        ready_d   = 1'b1;
                        state_d   = COMMIT;
                    end else begin
                        moving_d  = 1'b0;
                        blocked_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                if (bus.done) begin
                    curr_x_d = next_x_q;
                    curr_y_d = next_y_q;
                    ready_d  = 1'b0;
                    state_d  = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= IDLE;
            curr_x_q     <= X_START;
            curr_y_q     <= Y_START;
            next_x_q     <= X_START;
            next_y_q     <= Y_START;
            probe_x_q    <= X_START;
            probe_y_q    <= Y_START;
            heading_q    <= 2'd2;
            want_dir_q   <= 2'd2;
            probe_dir_q  <= 2'd2;
            moving_q     <= 1'b0;
            want_valid_q <= 1'b0;
            probe_req_q  <= 1'b0;
            off_q        <= 1'b0;
            ready_q      <= 1'b0;
            blocked_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            curr_x_q     <= curr_x_d;
            curr_y_q     <= curr_y_d;
            next_x_q     <= next_x_d;
            next_y_q     <= next_y_d;
            probe_x_q    <= probe_x_d;
            probe_y_q    <= probe_y_d;
            heading_q    <= heading_d;
            want_dir_q   <= want_dir_d;
            probe_dir_q  <= probe_dir_d;
            moving_q     <= moving_d;
            want_valid_q <= want_valid_d;
            probe_req_q  <= probe_req_d;
            off_q        <= off_d;
            ready_q      <= ready_d;
            blocked_q    <= blocked_d;
        end
    end

    assign bus.probe_req = probe_req_q;
    assign bus.probe_x   = probe_x_q;
    assign bus.probe_y   = probe_y_q;
    assign bus.ready     = ready_q;
    assign bus.next_x    = next_x_q;
    assign bus.next_y    = next_y_q;
    assign curr_x        = curr_x_q;
    assign curr_y        = curr_y_q;
    assign heading       = heading_q;
    assign moving        = moving_q;
    assign blocked       = blocked_q;
endmodule

// File: tb/tb_sprite_loc_ctrl.sv
// Scoreboard bench: expected probes and committed moves are queued by the stimulus;
// a probe responder and a ready monitor pop and compare as the DUT presents them.
module tb_sprite_loc_ctrl;
    typedef struct { int x; int y; bit wall; } probe_t;
    typedef struct { int x; int y; } cell_t;

    logic CLOCK_50, reset;
    logic up, down, left, right, step;
    logic left0, step0;
    logic [5:0] curr_x, curr_x0;
    logic [4:0] curr_y, curr_y0;
    logic [1:0] heading, heading0;
    logic moving, blocked, moving0, blocked0;
    logic rdy_prev;

    int checks = 0;
    int errors = 0;
    int ack_dly = 0;
    int probe0_seen = 0;
    int lat;
    probe_t probe_q[$];
    cell_t  move_q[$];

    sprite_loc_ctrl_if #(.X_W(6), .Y_W(5)) bus ();
    sprite_loc_ctrl_if #(.X_W(6), .Y_W(5)) bus0 ();

    sprite_loc_ctrl dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .up(up), .down(down), .left(left), .right(right), .step(step),
        .bus(bus),
        .curr_x(curr_x), .curr_y(curr_y), .heading(heading),
        .moving(moving), .blocked(blocked)
    );

    sprite_loc_ctrl #(.START_X(0), .START_Y(20), .WRAP(0)) dut0 (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .up(1'b0), .down(1'b0), .left(left0), .right(1'b0), .step(step0),
        .bus(bus0),
        .curr_x(curr_x0), .curr_y(curr_y0), .heading(heading0),
        .moving(moving0), .blocked(blocked0)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic pulse_dir(input int d);
        up = (d == 0); down = (d == 1); left = (d == 2); right = (d == 3);
        tick(1);
        up = 0; down = 0; left = 0; right = 0;
    endtask

    task automatic do_step();
        step = 1;
        tick(1);
        step = 0;
    endtask

    task automatic wait_ready(output int l);
        l = 1;
        while (!bus.ready && l < 60) begin
            tick(1);
            l++;
        end
        check("ready_timeout", int'(bus.ready), 1);
    endtask

    task automatic do_done();
        bus.done = 1;
        tick(1);
        bus.done = 0;
    endtask

    task automatic expect_move(input int x, input int y);
        probe_q.push_back('{x, y, 1'b0});
        move_q.push_back('{x, y});
    endtask

    // Map RAM model: answers each request after ack_dly cycles with the queued wall bit.
    initial begin
        probe_t p;
        bus.probe_ack = 0;
        bus.probe_wall = 0;
        forever begin
            @(posedge CLOCK_50); #1;
            while (bus.probe_req) begin
                if (probe_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_probe actual=(%0d,%0d) expected=none",
                             bus.probe_x, bus.probe_y);
                    p = '{int'(bus.probe_x), int'(bus.probe_y), 1'b0};
                end else begin
                    p = probe_q.pop_front();
                    check("probe_x", int'(bus.probe_x), p.x);
                    check("probe_y", int'(bus.probe_y), p.y);
                end
                repeat (ack_dly) @(posedge CLOCK_50);
                @(negedge CLOCK_50);
                bus.probe_ack = 1;
                bus.probe_wall = p.wall;
                @(posedge CLOCK_50); #1;
                bus.probe_ack = 0;
                bus.probe_wall = 0;
            end
        end
    end

    initial begin
        cell_t m;
        rdy_prev = 0;
        forever begin
            @(posedge CLOCK_50); #1;
            if (bus.ready && !rdy_prev) begin
                if (move_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ready actual=(%0d,%0d) expected=none",
                             bus.next_x, bus.next_y);
                end else begin
                    m = move_q.pop_front();
                    check("commit_next_x", int'(bus.next_x), m.x);
                    check("commit_next_y", int'(bus.next_y), m.y);
                end
            end
            rdy_prev = bus.ready;
            if (bus0.probe_req) probe0_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; up = 0; down = 0; left = 0; right = 0; step = 0;
        left0 = 0; step0 = 0;
        bus.done = 0; bus0.done = 0; bus0.probe_ack = 0; bus0.probe_wall = 0;
        tick(3);
        reset = 0;
        tick(1);

        // T1: reset state, step with nothing buffered
        check("rst_curr_x", int'(curr_x), 20);
        check("rst_curr_y", int'(curr_y), 20);
        check("rst_next_x", int'(bus.next_x), 20);
        check("rst_next_y", int'(bus.next_y), 20);
        check("rst_ready", int'(bus.ready), 0);
        check("rst_moving", int'(moving), 0);
        check("rst_heading", int'(heading), 2);
        check("rst_blocked", int'(blocked), 0);
        do_step();
        tick(3);
        check("idle_step_probe_req", int'(bus.probe_req), 0);
        check("idle_step_curr_x", int'(curr_x), 20);

        // T5b: WRAP=0 at x=0 moving left is an immediate wall
        left0 = 1; tick(1); left0 = 0;
        step0 = 1; tick(1); step0 = 0;
        tick(3);
        check("nowrap_blocked", int'(blocked0), 1);
        check("nowrap_moving", int'(moving0), 0);
        check("nowrap_curr_x", int'(curr_x0), 0);
        check("nowrap_ready", int'(bus0.ready), 0);
        check("nowrap_probe_seen", probe0_seen, 0);

        // T2: turn left, ack after 2 cycles
        ack_dly = 2;
        pulse_dir(2);
        expect_move(19, 20);
        do_step();
        wait_ready(lat);
        check("t2_latency", lat, 4);
        check("t2_curr_before_done", int'(curr_x), 20);
        do_done();
        check("t2_ready_after_done", int'(bus.ready), 0);
        check("t2_curr_x", int'(curr_x), 19);
        check("t2_heading", int'(heading), 2);
        check("t2_moving", int'(moving), 1);

        // T3: want up walled, heading left open
        pulse_dir(0);
        probe_q.push_back('{19, 19, 1'b1});
        expect_move(18, 20);
        do_step();
        wait_ready(lat);
        check("t3_latency", lat, 7);
        do_done();
        check("t3_curr_x", int'(curr_x), 18);
        check("t3_heading", int'(heading), 2);

        // T4: want down and heading left both walled
        ack_dly = 1;
        pulse_dir(1);
        probe_q.push_back('{18, 21, 1'b1});
        probe_q.push_back('{17, 20, 1'b1});
        do_step();
        tick(12);
        check("t4_ready", int'(bus.ready), 0);
        check("t4_blocked", int'(blocked), 1);
        check("t4_moving", int'(moving), 0);
        check("t4_curr_x", int'(curr_x), 18);
        check("t4_next_x", int'(bus.next_x), 18);

        // T5: run left to x=0, then wrap to x=39
        pulse_dir(2);
        for (int x = 18; x >= 1; x--) begin
            ack_dly = x % 3;
            expect_move(x - 1, 20);
            do_step();
            wait_ready(lat);
            do_done();
            check("t5_curr_x", int'(curr_x), x - 1);
        end
        check("t5_blocked_cleared", int'(blocked), 0);
        expect_move(39, 20);
        do_step();
        wait_ready(lat);
        do_done();
        check("wrap_curr_x", int'(curr_x), 39);
        check("wrap_curr_y", int'(curr_y), 20);

        // T6: turn right wraps to 0, step in COMMIT ignored, reset aborts handshake
        ack_dly = 0;
        pulse_dir(3);
        expect_move(0, 20);
        do_step();
        wait_ready(lat);
        check("t6_latency", lat, 2);
        check("t6_heading", int'(heading), 3);
        do_step();
        tick(3);
        check("commit_step_ready", int'(bus.ready), 1);
        check("commit_step_curr_x", int'(curr_x), 39);
        check("commit_step_next_x", int'(bus.next_x), 0);
        reset = 1;
        tick(1);
        reset = 0;
        check("abort_ready", int'(bus.ready), 0);
        check("abort_curr_x", int'(curr_x), 20);
        check("abort_next_x", int'(bus.next_x), 20);
        check("abort_moving", int'(moving), 0);
        check("abort_heading", int'(heading), 2);
        do_done();
        tick(2);
        check("idle_done_curr_x", int'(curr_x), 20);
        check("idle_done_ready", int'(bus.ready), 0);
        do_step();
        tick(4);
        check("post_reset_step_curr_x", int'(curr_x), 20);

        check("probe_q_left", probe_q.size(), 0);
        check("move_q_left", move_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
